// File: rtl/load_store_sequencer.sv
// ============================================================================
//  Module   : load_store_sequencer
//  Purpose  : Sequences one LOAD/STORE micro-op at a time into the BRAM fetch
//             datapath and raises PE write strobes aligned to BRAM latency.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int BRAM_LAT    = 1,
  parameter int STORE_BEATS = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              INS_VALID,
  output logic              INS_READY,
  input  logic              INS_STORE,
  input  logic [1:0]        INS_DIMEN,
  input  logic [ADDR_W-1:0] INS_ADDR,
  input  logic [1:0]        INS_PE_SEL,
  input  logic              INS_PE_SEL_2x2,
  input  logic              INS_PE_SEL_4,
  output logic [1:0]        DIMEN,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [1:0]        PE_SEL,
  output logic              PE_SEL_2x2,
  output logic              PE_SEL_4,
  output logic              ADDR_RST,
  output logic              ADDR_START,
  output logic              WRADDR_START,
  input  logic              STORE_DONE,
  output logic              PE_WE,
  output logic [3:0]        PE_WR_IDX,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_LOAD  = 3'd2,
    S_STORE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [4:0] c_store_last = 5'(STORE_BEATS - 1);

  state_t     r_state;
  logic [4:0] r_cnt;
  logic       r_store;
  logic [4:0] w_beats;

  // The 5-bit counter is needed because a DIMEN=3 load runs to count 16.
  assign w_beats = 5'd2 << DIMEN;

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      r_state      <= S_IDLE;
      r_cnt        <= 5'd0;
      r_store      <= 1'b0;
      INS_READY    <= 1'b1;
      DIMEN        <= 2'd0;
      ADDRESS      <= '0;
      PE_SEL       <= 2'd0;
      PE_SEL_2x2   <= 1'b0;
      PE_SEL_4     <= 1'b0;
      ADDR_RST     <= 1'b1;
      ADDR_START   <= 1'b0;
      WRADDR_START <= 1'b0;
      PE_WE        <= 1'b0;
      PE_WR_IDX    <= 4'd0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      ERR          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (INS_VALID && INS_READY) begin
            r_store    <= INS_STORE;
            DIMEN      <= INS_DIMEN;
            ADDRESS    <= INS_ADDR;
            PE_SEL     <= INS_PE_SEL;
            PE_SEL_2x2 <= INS_PE_SEL_2x2;
            PE_SEL_4   <= INS_PE_SEL_4;
            INS_READY  <= 1'b0;
            BUSY       <= 1'b1;
            ADDR_RST   <= 1'b1;
            r_state    <= S_CLR;
          end
        end

        S_CLR: begin
          r_cnt    <= 5'd0;
          ADDR_RST <= 1'b0;
          if (r_store) begin
            WRADDR_START <= 1'b1;
            r_state      <= S_STORE;
          end else begin
            ADDR_START <= 1'b1;
            r_state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (r_cnt == w_beats) begin
            ADDR_START <= 1'b0;
            PE_WE      <= 1'b0;
            ADDR_RST   <= 1'b1;
            DONE       <= 1'b1;
            r_state    <= S_FIN;
          end else begin
            // Data for offset c lands one cycle later, tagged with index c.
            r_cnt     <= r_cnt + 5'd1;
            PE_WE     <= 1'b1;
            PE_WR_IDX <= r_cnt[3:0];
          end
        end

        S_STORE: begin
          if ((r_cnt == c_store_last) != STORE_DONE)
            ERR <= 1'b1;
          if (r_cnt == c_store_last) begin
            WRADDR_START <= 1'b0;
            ADDR_RST     <= 1'b1;
            DONE         <= 1'b1;
            r_state      <= S_FIN;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end

        S_FIN: begin
          DONE      <= 1'b0;
          BUSY      <= 1'b0;
          INS_READY <= 1'b1;
          PE_WR_IDX <= 4'd0;
          r_state   <= S_IDLE;
        end

        default: begin
          r_state      <= S_IDLE;
          INS_READY    <= 1'b1;
          ADDR_RST     <= 1'b1;
          ADDR_START   <= 1'b0;
          WRADDR_START <= 1'b0;
          PE_WE        <= 1'b0;
          BUSY         <= 1'b0;
          DONE         <= 1'b0;
        end
      endcase
    end
  end

  a_bram_lat: assert property (@(posedge CLK) BRAM_LAT == 1)
    else $error("load_store_sequencer supports BRAM_LAT == 1 only");

  a_no_overlap: assert property (@(posedge CLK)
    !(ADDR_RST && (ADDR_START || WRADDR_START)))
    else $error("ADDR_RST overlaps a start strobe");

endmodule

`default_nettype wire

// File: doc/load_store_sequencer.md
Name: load_store_sequencer

Overview:
- Control stage directly upstream of the BRAM data-fetch datapath.
- Accepts one LOAD/STORE micro-op at a time over a valid/ready handshake and latches its fields.
- Drives the fetch datapath's ADDR_RST / ADDR_START / WRADDR_START strobes and holds DIMEN, ADDRESS and PE-select stable for the whole operation.
- Generates per-beat PE write strobes aligned to the 1-cycle BRAM read latency, then reports completion.

Parameters:
- ADDR_W, 4, width of the base-address field forwarded as ADDRESS.
- BRAM_LAT, 1, BRAM read latency in cycles; fixed at 1 in this revision and checked by assertion.
- STORE_BEATS, 4, words written per STORE (one per PE).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RSTN  in  1  synchronous reset, active-high (asserted = 1 resets on the next CLK edge).
- INS_VALID  in  1  micro-op valid.
- INS_READY  out  1  sequencer can accept a micro-op.
- INS_STORE  in  1  0 = LOAD, 1 = STORE.
- INS_DIMEN  in  2  LOAD length code.
- INS_ADDR  in  ADDR_W  BRAM base address.
- INS_PE_SEL  in  2  PE routing mode.
- INS_PE_SEL_2x2  in  1  routing qualifier.
- INS_PE_SEL_4  in  1  routing qualifier.
- DIMEN  out  2  latched length code to fetch datapath.
- ADDRESS  out  ADDR_W  latched base address.
- PE_SEL  out  2  latched routing mode.
- PE_SEL_2x2  out  1  latched routing qualifier.
- PE_SEL_4  out  1  latched routing qualifier.
- ADDR_RST  out  1  clears the datapath address offset.
- ADDR_START  out  1  read-phase strobe; advances the offset.
- WRADDR_START  out  1  write-phase strobe; advances the offset.
- STORE_DONE  in  1  datapath indicates offset == 3.
- PE_WE  out  1  PEs capture routed data this cycle.
- PE_WR_IDX  out  4  beat index of the word on PE_WE.
- BUSY  out  1  operation in progress.
- DONE  out  1  single-cycle completion pulse.
- ERR  out  1  sticky: STORE_DONE disagreed with the internal beat count.

Behaviour:
- Reset values: state IDLE; INS_READY=1; ADDR_RST=1; all other strobes, PE_WE, DONE, BUSY, ERR = 0; latched fields = 0.
- Beat count N = 2^(DIMEN+1): 2, 4, 8 or 16. The internal 5-bit beat counter is authoritative for LOAD termination; FETCH_DONE is not consumed because it cannot encode 16.
- IDLE:
  - INS_READY=1 and ADDR_RST=1.
  - On INS_VALID&INS_READY, latch all INS_* fields and go to CLR.
- CLR (1 cycle):
  - ADDR_RST=1, BUSY=1.
  - Go to LOAD if INS_STORE=0, otherwise STORE.
- LOAD (N+1 cycles, beat counter c = 0..N):
  - ADDR_START=1 throughout.
  - PE_WE=1 for c = 1..N, with PE_WR_IDX = c-1, because BRAM data for offset k appears one cycle after offset k is presented.
  - After c = N, go to FIN.
- STORE (STORE_BEATS cycles, c = 0..3):
  - WRADDR_START=1 throughout; PE_WE=0.
  - Exit to FIN after c = 3.
  - If STORE_DONE=1 at any c≠3, or is 0 at c=3, set ERR; sequencing still completes.
- FIN (1 cycle):
  - DONE=1, ADDR_RST=1, BUSY=1; return to IDLE.
  - INS_READY rises in the next cycle, so there are no back-to-back accepts without an IDLE cycle.
- Latched outputs (DIMEN, ADDRESS, PE_SEL*) hold from acceptance until the next acceptance and do not change mid-operation.
- INS_* changes while BUSY are ignored.
- Reset mid-operation: returns to IDLE on the next edge with reset values. No DONE pulse; ERR is cleared.
- ERR is sticky until reset.
- ADDR_RST and ADDR_START/WRADDR_START are never high in the same cycle.
- Latency from accept to DONE:
  - LOAD: N+3 cycles (CLR + N+1 + FIN).
  - STORE: 6 cycles (CLR + 4 + FIN).

Test Plan:
- Reset then idle: hold RSTN=1 for 2 cycles, release → INS_READY=1, ADDR_RST=1, BUSY=0, DONE=0, ERR=0.
- LOAD, DIMEN=0, INS_ADDR=4'h5, PE_SEL=0 → ADDRESS=5 from the next cycle; ADDR_START high 3 cycles; PE_WE on cycles 2–3 of LOAD with PE_WR_IDX 0,1; DONE exactly 5 cycles after accept.
- LOAD, DIMEN=3 → 17 ADDR_START cycles; 16 PE_WE beats with PE_WR_IDX 0..15; DONE at cycle 19; the wrap at count 16 is handled without hang.
- STORE with a model asserting STORE_DONE at offset 3 → WRADDR_START high 4 cycles, no PE_WE, DONE at cycle 6, ERR=0. Repeat with STORE_DONE forced at offset 2 → ERR=1 and stays 1 until reset.
- Mid-LOAD reset (RSTN=1 at beat 5 of DIMEN=2) → next cycle IDLE, ADDR_START=0, no DONE; a following LOAD completes normally.
- Hold INS_VALID high continuously with alternating LOAD/STORE → one accept per operation; INS_READY low from CLK after accept through FIN; latched fields stable per op; never ADDR_RST together with a start strobe.
